// File: rtl/dac_spi_tx.sv
// dac_spi_tx: write-only SPI serializer for the loop-filter/tuning DAC.
// Accepts parallel words over valid/ready and emits CPOL=1, MSB-first frames
// on dac = {mosi, sclk, cs_n}. The DAC samples mosi on sclk falling edges.
module dac_spi_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dac
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_GAP
  } state_t;

  state_t          state;
  // Holds the bits still to be sent, left-aligned; the MSB goes out directly.
  logic [WIDTH-1:0] shreg;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            mosi;
  logic            sclk;
  logic            cs_n;
  logic            div_last;

  // End of the current DIV-cycle half-period
  assign div_last = (div_cnt == DW'(DIV - 1));

  assign dac = {mosi, sclk, cs_n};

  // Frame sequencer; mosi moves only on sclk rise or at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      mosi     <= 1'b0;
      sclk     <= 1'b1;
      cs_n     <= 1'b1;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          wr_ready <= 1'b1;
          busy     <= 1'b0;
          if (wr_valid && wr_ready) begin
            shreg    <= wr_data << 1;
            mosi     <= wr_data[WIDTH-1];
            cs_n     <= 1'b0;
            sclk     <= 1'b1;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= BW'(WIDTH - 1);
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= S_SHIFT_LO;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        S_SHIFT_LO: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= S_SHIFT_HI;
            if (bit_cnt != '0) begin
              mosi  <= shreg[WIDTH-1];
              shreg <= shreg << 1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        S_SHIFT_HI: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - BW'(1);
              sclk    <= 1'b0;
              state   <= S_SHIFT_LO;
            end else begin
              cs_n <= 1'b1;
              mosi <= 1'b0;
              done <= 1'b1;
              if (GAP == 0) begin
                wr_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            gap_cnt  <= '0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default instance (16/4/2) and a fast
// variant (WIDTH=8, DIV=1, GAP=0).
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_wr_data;
  logic        a_wr_valid;
  logic        a_wr_ready, a_busy, a_done;
  logic [2:0]  a_dac;
  logic [7:0]  b_wr_data;
  logic        b_wr_valid;
  logic        b_wr_ready, b_busy, b_done;
  logic [2:0]  b_dac;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dac_spi_tx u_a (
    .clk(clk), .rst_n(rst_n), .wr_data(a_wr_data), .wr_valid(a_wr_valid),
    .wr_ready(a_wr_ready), .busy(a_busy), .done(a_done), .dac(a_dac)
  );

  dac_spi_tx #(.WIDTH(8), .DIV(1), .GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_data(b_wr_data), .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready), .busy(b_busy), .done(b_done), .dac(b_dac)
  );

  logic v_ready, v_busy, v_done, v_mosi, v_sclk, v_cs;
  always_comb begin
    v_ready = (sel != 0) ? b_wr_ready : a_wr_ready;
    v_busy  = (sel != 0) ? b_busy     : a_busy;
    v_done  = (sel != 0) ? b_done     : a_done;
    v_mosi  = (sel != 0) ? b_dac[2]   : a_dac[2];
    v_sclk  = (sel != 0) ? b_dac[1]   : a_dac[1];
    v_cs    = (sel != 0) ? b_dac[0]   : a_dac[0];
  end

  typedef struct {
    logic [15:0] word;
    int falls, cs_low, busy_cnt, done_rel, done_cnt, ready_rel;
    int lo_min, lo_max, hi_min, hi_max, extra;
  } frame_t;

  task automatic set_in(input logic [15:0] d, input logic v);
    if (sel == 0) begin a_wr_data = d;      a_wr_valid = v; end
    else          begin b_wr_data = d[7:0]; b_wr_valid = v; end
  endtask

  // Raise valid and wait for ready; t is the index of the handshake edge
  task automatic do_hs(input logic [15:0] d, output int t);
    t = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      set_in(d, 1'b1);
      if (v_ready) begin t = cyc + 1; break; end
    end
  endtask

  // Observe one frame from handshake edge t until wr_ready returns
  task automatic capture(input int t, input bit drop_valid, input bit noise,
                         input logic [15:0] next_d, output frame_t f);
    logic prev;
    int run, rel;
    f.word = '0; f.falls = 0; f.cs_low = 0; f.busy_cnt = 0; f.done_rel = -1;
    f.done_cnt = 0; f.ready_rel = -1; f.lo_min = 1000; f.lo_max = 0;
    f.hi_min = 1000; f.hi_max = 0; f.extra = 0;
    prev = 1'b1;
    run = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rel = cyc - t + 1;
      if (i == 0) set_in(next_d, !drop_valid);
      if (noise) set_in(16'($urandom), 1'((i % 3) == 1));
      if (!v_cs) f.cs_low++;
      if (v_busy) f.busy_cnt++;
      if (v_done) begin f.done_cnt++; f.done_rel = rel; end
      if (v_sclk != prev) begin
        if (v_cs) f.extra++;
        if (!v_sclk && !v_cs) begin f.word = {f.word[14:0], v_mosi}; f.falls++; end
        if (!prev) begin
          if (run < f.lo_min) f.lo_min = run;
          if (run > f.lo_max) f.lo_max = run;
        end else begin
          if (run < f.hi_min) f.hi_min = run;
          if (run > f.hi_max) f.hi_max = run;
        end
        run = 1;
      end else begin
        run++;
      end
      prev = v_sclk;
      if (v_ready) begin
        f.ready_rel = rel;
        if (noise) set_in(16'h0000, 1'b0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_dac, a_wr_ready, a_busy, a_done} !== 6'b011_000) begin
        errors++;
        $display("FAIL reset_hold: dac=%b rdy=%b busy=%b done=%b want dac=011 rdy/busy/done=0",
                 a_dac, a_wr_ready, a_busy, a_done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_dac, a_wr_ready, a_busy, a_done} !== 6'b011_100) begin
      errors++;
      $display("FAIL reset_release: dac=%b rdy=%b busy=%b done=%b want 011 1 0 0",
               a_dac, a_wr_ready, a_busy, a_done);
    end
    checks++;
    if ({b_dac, b_wr_ready} !== 4'b011_1) begin
      errors++;
      $display("FAIL reset_release_b: dac=%b rdy=%b want 011 1", b_dac, b_wr_ready);
    end
  endtask

  task automatic test_single();
    int t;
    frame_t f;
    do_hs(16'hA5C3, t);
    capture(t, 1'b1, 1'b0, 16'h0000, f);
    checks++;
    if (f.word !== 16'hA5C3) begin errors++; $display("FAIL single_word: got %h want a5c3", f.word); end
    checks++;
    if (f.falls != 16) begin errors++; $display("FAIL single_falls: got %0d want 16", f.falls); end
    checks++;
    if (f.cs_low != 132) begin errors++; $display("FAIL single_cs_low: got %0d want 132", f.cs_low); end
    checks++;
    if (f.done_rel != 133 || f.done_cnt != 1) begin
      errors++; $display("FAIL single_done: at T+%0d count %0d want T+133 count 1", f.done_rel, f.done_cnt);
    end
    checks++;
    if (f.ready_rel != 135) begin errors++; $display("FAIL single_ready: got T+%0d want T+135", f.ready_rel); end
    checks++;
    if (f.busy_cnt != 134) begin errors++; $display("FAIL single_busy: got %0d want 134", f.busy_cnt); end
    checks++;
    if (f.lo_min != 4 || f.lo_max != 4 || f.hi_min != 4 || f.hi_max != 4) begin
      errors++;
      $display("FAIL single_phase: lo %0d..%0d hi %0d..%0d want 4..4", f.lo_min, f.lo_max, f.hi_min, f.hi_max);
    end
    checks++;
    if (f.extra != 0) begin errors++; $display("FAIL single_idle_edges: got %0d want 0", f.extra); end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    frame_t f1, f2;
    do_hs(16'hFFFF, t1);
    capture(t1, 1'b0, 1'b0, 16'h0001, f1);
    t2 = cyc + 1;
    capture(t2, 1'b1, 1'b0, 16'h0000, f2);
    checks++;
    if (t2 - t1 != 135) begin errors++; $display("FAIL b2b_spacing: got %0d want 135", t2 - t1); end
    checks++;
    if (f1.word !== 16'hFFFF || f1.falls != 16) begin
      errors++; $display("FAIL b2b_first: got %h/%0d want ffff/16", f1.word, f1.falls);
    end
    checks++;
    if (f2.word !== 16'h0001 || f2.falls != 16) begin
      errors++; $display("FAIL b2b_second: got %h/%0d want 0001/16", f2.word, f2.falls);
    end
    checks++;
    if (f2.cs_low != 132 || f2.done_cnt != 1) begin
      errors++; $display("FAIL b2b_second_frame: cs_low %0d done %0d want 132 1", f2.cs_low, f2.done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int t, falls, dones;
    logic prev;
    frame_t f;
    do_hs(16'h1234, t);
    falls = 0;
    dones = 0;
    prev = 1'b1;
    for (int i = 0; i < 200 && falls < 7; i++) begin
      @(negedge clk);
      if (i == 0) a_wr_valid = 1'b0;
      if (a_done) dones++;
      if (prev && !a_dac[1] && !a_dac[0]) falls++;
      prev = a_dac[1];
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (falls != 7) begin errors++; $display("FAIL midrst_falls: got %0d want 7", falls); end
    checks++;
    if ({a_dac, a_wr_ready, a_busy, a_done} !== 6'b011_000) begin
      errors++;
      $display("FAIL midrst_outputs: dac=%b rdy=%b busy=%b done=%b want 011 0 0 0",
               a_dac, a_wr_ready, a_busy, a_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_done) dones++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (a_done) dones++;
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", dones); end
    do_hs(16'h8001, t);
    capture(t, 1'b1, 1'b0, 16'h0000, f);
    checks++;
    if (f.word !== 16'h8001 || f.falls != 16 || f.done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_after: got %h/%0d/%0d want 8001/16/1", f.word, f.falls, f.done_cnt);
    end
  endtask

  task automatic test_ignored_inputs();
    int t;
    frame_t f;
    do_hs(16'h3C5A, t);
    capture(t, 1'b1, 1'b1, 16'h0000, f);
    checks++;
    if (f.word !== 16'h3C5A || f.falls != 16) begin
      errors++; $display("FAIL ignore_word: got %h/%0d want 3c5a/16", f.word, f.falls);
    end
    checks++;
    if (f.done_cnt != 1 || f.ready_rel != 135) begin
      errors++; $display("FAIL ignore_timing: done %0d ready T+%0d want 1 T+135", f.done_cnt, f.ready_rel);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_dac !== 3'b011) begin
      errors++; $display("FAIL ignore_idle: busy=%b dac=%b want 0 011", a_busy, a_dac);
    end
  endtask

  task automatic test_variant();
    int t1, t2;
    frame_t f1, f2;
    sel = 1;
    do_hs(16'h0096, t1);
    capture(t1, 1'b0, 1'b0, 16'h00A5, f1);
    t2 = cyc + 1;
    capture(t2, 1'b1, 1'b0, 16'h0000, f2);
    checks++;
    if (f1.word[7:0] !== 8'h96 || f1.falls != 8) begin
      errors++; $display("FAIL var_word: got %h/%0d want 96/8", f1.word[7:0], f1.falls);
    end
    checks++;
    if (f1.cs_low != 17) begin errors++; $display("FAIL var_cs_low: got %0d want 17", f1.cs_low); end
    checks++;
    if (f1.done_rel != 18 || f1.ready_rel != 18 || f1.busy_cnt != 17) begin
      errors++;
      $display("FAIL var_done_ready: done T+%0d ready T+%0d busy %0d want 18 18 17",
               f1.done_rel, f1.ready_rel, f1.busy_cnt);
    end
    checks++;
    if (f1.lo_min != 1 || f1.lo_max != 1 || f1.hi_min != 1 || f1.hi_max != 1) begin
      errors++;
      $display("FAIL var_phase: lo %0d..%0d hi %0d..%0d want 1..1", f1.lo_min, f1.lo_max, f1.hi_min, f1.hi_max);
    end
    checks++;
    if (t2 - t1 != 18 || (t2 - t1) - f1.cs_low != 1) begin
      errors++; $display("FAIL var_b2b_gap: spacing %0d high %0d want 18 1", t2 - t1, (t2 - t1) - f1.cs_low);
    end
    checks++;
    if (f2.word[7:0] !== 8'hA5 || f2.falls != 8 || f2.done_cnt != 1) begin
      errors++; $display("FAIL var_second: got %h/%0d/%0d want a5/8/1", f2.word[7:0], f2.falls, f2.done_cnt);
    end
    sel = 0;
  endtask

  initial begin
    a_wr_data = '0; a_wr_valid = 1'b0;
    b_wr_data = '0; b_wr_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_reset();
    test_ignored_inputs();
    test_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
